// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares one ALU between two requesters. One operation is accepted at a time
// through a valid/ready handshake, with round-robin arbitration. The accepted
// operation is issued to the ALU with a one-cycle enable. The arbiter then
// waits for the ALU valid flag and returns the result to the granted requester.
// A timeout guard returns an error response if the ALU never answers.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for requester N (0, 1)
//   reqN_a, reqN_b, reqN_fun       operands and function code of requester N
//   rspN_valid                     one-cycle response pulse for requester N
//   rsp_data, rsp_err              response payload, qualified by rspN_valid
//   alu_a, alu_b, alu_fun          operands held towards the ALU
//   alu_enable                     one-cycle ALU start pulse
//   alu_out, alu_out_valid         ALU result and its valid flag
//   busy                           high whenever an operation is in flight
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [IN_WIDTH-1:0]  req0_a,
    input  logic [IN_WIDTH-1:0]  req0_b,
    input  logic [3:0]           req0_fun,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [IN_WIDTH-1:0]  req1_a,
    input  logic [IN_WIDTH-1:0]  req1_b,
    input  logic [3:0]           req1_fun,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [OUT_WIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [IN_WIDTH-1:0]  alu_a,
    output logic [IN_WIDTH-1:0]  alu_b,
    output logic [3:0]           alu_fun,
    output logic                 alu_enable,
    input  logic [OUT_WIDTH-1:0] alu_out,
    input  logic                 alu_out_valid,
    output logic                 busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic                   last_grant_reg, last_grant_next;
    logic                   grant_reg, grant_next;
    logic [IN_WIDTH-1:0]    alu_a_reg, alu_a_next;
    logic [IN_WIDTH-1:0]    alu_b_reg, alu_b_next;
    logic [3:0]             alu_fun_reg, alu_fun_next;
    logic [OUT_WIDTH-1:0]   rsp_data_reg, rsp_data_next;
    logic                   rsp_err_reg, rsp_err_next;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic       pick;

    assign req_valid = {req1_valid, req0_valid};

    // Under contention the requester that was not served last wins;
    // otherwise whichever one is asking (requester 1 only if it is the sole one).
    assign pick = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (pick == 1'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign alu_enable = (state_reg == ISSUE);
    assign busy       = (state_reg != IDLE);
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_fun    = alu_fun_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_err    = rsp_err_reg;

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_fun_next    = alu_fun_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                if (|req_ready) begin
                    alu_a_next   = pick ? req1_a   : req0_a;
                    alu_b_next   = pick ? req1_b   : req0_b;
                    alu_fun_next = pick ? req1_fun : req0_fun;
                    grant_next   = pick;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A valid arriving on the final timeout cycle still counts.
                if (alu_out_valid) begin
                    rsp_data_next = alu_out;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else if (timer_reg == TIMER_LAST) begin
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RESP: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_fun_reg    <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_fun_reg    <= alu_fun_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Testbench for alu_req_arbiter. A per-cycle vector table covers the
// single-request, contention, timeout, stray-valid, reset-in-WAIT and
// last-cycle-valid cases. After that, random traffic is checked against a
// transaction-level reference model. The ALU is modelled here with a
// programmable response delay.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int IW = 8;
    localparam int OW = 16;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [IW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_fun = '0, req1_fun = '0;
    logic          rsp0_valid, rsp1_valid;
    logic [OW-1:0] rsp_data;
    logic          rsp_err;
    logic [IW-1:0] alu_a, alu_b;
    logic [3:0]    alu_fun;
    logic          alu_enable;
    logic [OW-1:0] alu_out;
    logic          alu_out_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_req_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .busy(busy)
    );

    // ALU behaviour: unit select in fun[3:2], operation in fun[1:0].
    function automatic logic [OW-1:0] alu_f(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                            input logic [3:0] f);
        logic [OW-1:0] xa, xb;
        xa = {8'b0, a};
        xb = {8'b0, b};
        case (f)
            4'h0: return xa + xb;
            4'h1: return xa - xb;
            4'h2: return xa * xb;
            4'h3: return xa;
            4'h4: return xa & xb;
            4'h5: return xa | xb;
            4'h6: return xa ^ xb;
            4'h7: return {8'b0, ~a};
            4'h8: return {15'b0, a == b};
            4'h9: return {15'b0, a < b};
            4'hA: return {15'b0, a > b};
            4'hB: return {15'b0, a != b};
            4'hC: return xa << b[2:0];
            4'hD: return xa >> b[2:0];
            4'hE: return xa << 1;
            default: return xa >> 1;
        endcase
    endfunction

    // ALU model: alu_delay = d raises valid in WAIT cycle d after the enable;
    // a negative delay never answers. 'stray' forces an extra valid pulse.
    int   alu_delay = 0;
    int   alu_cnt = 0;
    bit   alu_pend = 1'b0;
    logic alu_vm = 1'b0;
    logic stray = 1'b0;
    assign alu_out_valid = alu_vm | stray;

    always @(posedge CLK) begin
        alu_vm <= 1'b0;
        if (RST) begin
            alu_pend <= 1'b0;
        end else if (alu_enable) begin
            alu_out <= alu_f(alu_a, alu_b, alu_fun);
            if (alu_delay == 0) begin
                alu_vm   <= 1'b1;
                alu_pend <= 1'b0;
            end else if (alu_delay > 0) begin
                alu_pend <= 1'b1;
                alu_cnt  <= alu_delay - 1;
            end else begin
                alu_pend <= 1'b0;
            end
        end else if (alu_pend) begin
            if (alu_cnt == 0) begin
                alu_vm   <= 1'b1;
                alu_pend <= 1'b0;
            end else begin
                alu_cnt <= alu_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One table row = one clock cycle: inputs, then outputs sampled at the
    // falling edge. ex = {req0_ready, req1_ready, alu_enable, busy, rsp0_valid, rsp1_valid}.
    typedef struct {
        bit          rst, v0, v1, str;
        int          dly;
        logic [5:0]  ex;
        bit          gid;
        bit          chkd;
        logic [15:0] data;
        bit          err;
        bit          chkz;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit v0, input bit v1, input bit str, input int dly,
                       input logic [5:0] ex, input bit gid, input bit chkd,
                       input logic [15:0] data, input bit err, input bit chkz);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.str = str; v.dly = dly; v.ex = ex;
        v.gid = gid; v.chkd = chkd; v.data = data; v.err = err; v.chkz = chkz;
        vecs.push_back(v);
    endtask

    logic [5:0] ctrl;
    assign ctrl = {req0_ready, req1_ready, alu_enable, busy, rsp0_valid, rsp1_valid};

    // Random-phase reference state (transaction level).
    bit            m_active;
    bit            m_last;
    bit            m_id;
    int            m_hs, m_resp, m_d;
    logic [IW-1:0] m_a, m_b;
    logic [3:0]    m_f;

    initial begin
        logic [15:0] res0, res1;
        logic [5:0]  ex;
        bit          ch, er0, er1, drop0, drop1;

        // ---------------- directed table ----------------
        // r0..r5: single request from 0
        add(0,0,0,0, 0, 6'b000000, 0, 1, 16'h0000, 0, 1);
        add(0,1,0,0, 0, 6'b100000, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b001100, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000100, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000110, 0, 1, 16'h0008, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 0, 1, 16'h0008, 0, 0);
        // r6..r7: reset restores last_grant and clears the response
        add(1,0,0,0, 0, 6'b000000, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 0, 1, 16'h0000, 0, 0);
        // r8..r23: continuous contention, grants 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            bit g;
            bit last_op;
            g = bit'(k % 2);
            last_op = (k == 3);
            add(0,1,1,0, 0, g ? 6'b010000 : 6'b100000, g, 0, 16'h0000, 0, 0);
            add(0,!last_op,!last_op,0, 0, 6'b001100, g, 0, 16'h0000, 0, 0);
            add(0,!last_op,!last_op,0, 0, 6'b000100, g, 0, 16'h0000, 0, 0);
            add(0,!last_op,!last_op,0, 0, g ? 6'b000101 : 6'b000110, g, 1,
                g ? 16'h0019 : 16'h0008, 0, 0);
        end
        // r24..r31: timeout on requester 0
        add(0,1,0,0,  0, 6'b100000, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, -1, 6'b001100, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < TO; k++) add(0,0,0,0, -1, 6'b000100, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, -1, 6'b000110, 0, 1, 16'h0000, 1, 0);
        add(0,0,0,0, -1, 6'b000000, 0, 1, 16'h0000, 1, 0);
        // r32..r39: stray valid in IDLE, then in RESP of a requester 1 op
        add(0,0,0,1, 0, 6'b000000, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 0, 1, 16'h0000, 1, 0);
        add(0,0,1,0, 0, 6'b010000, 1, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b001100, 1, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000100, 1, 0, 16'h0000, 0, 0);
        add(0,0,0,1, 0, 6'b000101, 1, 1, 16'h0019, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 1, 1, 16'h0019, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 1, 0, 16'h0000, 0, 0);
        // r40..r43: reset while requester 1 waits in WAIT
        add(0,0,1,0,  0, 6'b010000, 1, 0, 16'h0000, 0, 0);
        add(0,0,0,0, -1, 6'b001100, 1, 0, 16'h0000, 0, 0);
        add(1,0,0,0, -1, 6'b000100, 1, 0, 16'h0000, 0, 0);
        add(0,0,0,0, -1, 6'b000000, 0, 1, 16'h0000, 0, 1);
        // r44..r51: contention after reset grants 0; valid on last timeout cycle
        add(0,1,1,0, 0, 6'b100000, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, TO-1, 6'b001100, 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < TO; k++) add(0,0,0,0, TO-1, 6'b000100, 0, 0, 16'h0000, 0, 0);
        add(0,0,0,0, 0, 6'b000110, 0, 1, 16'h0008, 0, 0);
        add(0,0,0,0, 0, 6'b000000, 0, 0, 16'h0000, 0, 0);

        req0_a = 8'h05; req0_b = 8'h03; req0_fun = 4'b0000;
        req1_a = 8'h20; req1_b = 8'h07; req1_fun = 4'b0001;
        res0 = 16'h0008;
        res1 = 16'h0019;

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            RST        = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            stray      = vecs[i].str;
            alu_delay  = vecs[i].dly;
            @(negedge CLK);
            chk($sformatf("row%0d ctrl", i), 32'(ctrl), 32'(vecs[i].ex));
            if (vecs[i].ex[3] && vecs[i].ex[2]) begin
                chk($sformatf("row%0d alu_ops", i), 32'({alu_a, alu_b, alu_fun}),
                    vecs[i].gid ? 32'({req1_a, req1_b, req1_fun}) : 32'({req0_a, req0_b, req0_fun}));
            end
            if (vecs[i].chkd) begin
                chk($sformatf("row%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].data));
                chk($sformatf("row%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].err));
            end
            if (vecs[i].chkz) begin
                chk($sformatf("row%0d alu_zero", i), 32'({alu_a, alu_b, alu_fun}), 32'h0);
            end
            @(posedge CLK);
            #1;
        end
        stray = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ---------------- random traffic vs reference model ----------------
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        m_active = 1'b0;
        m_last   = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_a = IW'($urandom); req0_b = IW'($urandom); req0_fun = 4'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_a = IW'($urandom); req1_b = IW'($urandom); req1_fun = 4'($urandom);
            end
            @(negedge CLK);
            er0 = 1'b0;
            er1 = 1'b0;
            if (!m_active) begin
                if (req0_valid && req1_valid) ch = !m_last;
                else                          ch = req1_valid;
                er0 = req0_valid && !ch;
                er1 = req1_valid && ch;
                ex  = {er0, er1, 4'b0000};
            end else begin
                ex = {2'b00, cyc == m_hs + 1, 1'b1,
                      cyc == m_resp && !m_id, cyc == m_resp && m_id};
            end
            chk($sformatf("rnd%0d ctrl", cyc), 32'(ctrl), 32'(ex));
            if (m_active && cyc == m_hs + 1) begin
                chk($sformatf("rnd%0d alu_ops", cyc), 32'({alu_a, alu_b, alu_fun}),
                    32'({m_a, m_b, m_f}));
            end
            if (m_active && cyc == m_resp) begin
                chk($sformatf("rnd%0d rsp_data", cyc), 32'(rsp_data),
                    (m_d < TO) ? 32'(alu_f(m_a, m_b, m_f)) : 32'h0);
                chk($sformatf("rnd%0d rsp_err", cyc), 32'(rsp_err), (m_d < TO) ? 32'h0 : 32'h1);
            end
            drop0 = 1'b0;
            drop1 = 1'b0;
            if (!m_active && (er0 || er1)) begin
                m_active = 1'b1;
                m_hs     = cyc;
                m_id     = er1;
                m_a      = er1 ? req1_a : req0_a;
                m_b      = er1 ? req1_b : req0_b;
                m_f      = er1 ? req1_fun : req0_fun;
                m_d      = $urandom_range(0, TO + 1);
                alu_delay = m_d;
                // Response after ISSUE plus the WAIT cycles actually spent.
                m_resp   = cyc + 3 + ((m_d < TO - 1) ? m_d : TO - 1);
                drop0    = er0;
                drop1    = er1;
            end else if (m_active && cyc == m_resp) begin
                m_active = 1'b0;
                m_last   = m_id;
            end
            @(posedge CLK);
            #1;
            if (drop0) req0_valid = 1'b0;
            if (drop1) req1_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single ALU datapath (arithmetic/logic/compare/shift units behind a 4-bit function code, registered result plus OUT_VALID) between two independent requesters.
- Accepts one operation at a time via valid/ready, arbitrates round-robin, and issues a one-cycle ALU enable.
- Waits for the ALU valid flag, then returns the result to the granted requester, with a timeout guard.
- Sits between the system controller / register-file command paths and the ALU top.

Parameters:
- IN_WIDTH, 8, operand width (A, B).
- OUT_WIDTH, 16, ALU result width.
- TIMEOUT, 4, max WAIT cycles for ALU valid before error response (>=1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  arbiter accepts requester 0 this cycle.
- req0_a, req0_b  input  IN_WIDTH  requester 0 operands.
- req0_fun  input  4  requester 0 function code ([3:2] unit select, [1:0] op).
- req1_valid, req1_ready, req1_a, req1_b, req1_fun  same as above, for requester 1.
- rsp0_valid  output  1  one-cycle pulse, result for requester 0.
- rsp1_valid  output  1  one-cycle pulse, result for requester 1.
- rsp_data  output  OUT_WIDTH  result, valid while rspX_valid is high.
- rsp_err  output  1  timeout flag, qualified by rspX_valid.
- alu_a, alu_b  output  IN_WIDTH  ALU operands.
- alu_fun  output  4  ALU function code.
- alu_enable  output  1  ALU enable, one-cycle pulse.
- alu_out  input  OUT_WIDTH  ALU result.
- alu_out_valid  input  1  ALU result valid.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, timer 0, last_grant=1, so requester 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only one reqX_valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - reqX_ready is combinational and high only in IDLE, only for the chosen requester, and only while its valid is high.
  - On handshake (valid & ready): register operands/fun into alu_a/alu_b/alu_fun, record the grant id, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - alu_enable=1 for exactly this cycle; go to WAIT; timer cleared to 0.
- WAIT:
  - alu_enable=0.
  - If alu_out_valid=1: capture alu_out into rsp_data, rsp_err=0, go to RESP.
  - Else, if timer==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
  - Else: timer+1.
  - If alu_out_valid and timeout coincide, valid wins (rsp_err=0).
- RESP:
  - rspX_valid=1 for the granted id only, one cycle.
  - last_grant <= granted id; go to IDLE.
- alu_a/alu_b/alu_fun hold their captured values from the handshake until the next handshake; they are never changed mid-operation.
- alu_out_valid in IDLE, ISSUE or RESP is ignored (stray/late valid never produces a response).
- rsp_data and rsp_err hold their last value outside RESP.
- Latency:
  - Handshake in cycle N, enable in N+1, ALU valid expected in N+2, rspX_valid in N+3.
  - Minimum 4 cycles per operation; no pipelining, one outstanding operation.
- No internal buffering: a non-granted requester keeps valid high; its data must stay stable until ready.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- Reset mid-operation: FSM returns to IDLE, the in-flight operation is dropped with no response, and all outputs clear the next cycle.
- Function code is passed through unchecked; unit decoding is the ALU's job.

Test Plan:
- Single request: reset, req0 valid with a=8'h05, b=8'h03, fun=4'b0000. Required: req0_ready in the cycle valid is presented; alu_enable pulses 1 cycle later with alu_a=5, alu_b=3; ALU model returns 16'h0008 the next cycle; rsp0_valid=1, rsp_data=16'h0008, rsp_err=0; rsp1_valid stays 0.
- Contention after reset: req0 and req1 valid simultaneously for 4 ops. Required: grant order 0,1,0,1, and each rsp_data matches the operands of the granted requester.
- Timeout: TIMEOUT=4, ALU model never raises valid. Required: exactly 4 WAIT cycles, then rsp_err=1, rsp_data=0 with the correct rspX_valid, and busy drops the cycle after.
- Late/stray valid: alu_out_valid pulsed while in IDLE and in RESP. Required: no extra rspX_valid and no state change.
- Reset mid-WAIT: assert RST while in WAIT for req1. Required: no rsp1_valid; next cycle all outputs 0 and busy=0; a following simultaneous request grants req0.
- Valid on last timeout cycle: ALU valid arrives in WAIT cycle TIMEOUT-1. Required: rsp_err=0 and rsp_data equals alu_out.
